// File: rtl/input_fifo_pkg.sv
// rtl/input_fifo_pkg.sv - shared sizing constants and operation decode for input_fifo
package input_fifo_pkg;

   // Router-wide defaults for the input buffer
   localparam int FIFO_DATA_WIDTH = 32;
   localparam int FIFO_DEPTH      = 4;
   localparam int FIFO_PTR_WIDTH  = 2;

   // Per-cycle FIFO activity: {write accepted, pop accepted}
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic fifo_op_e decode_op(input logic wr, input logic rd);
      return fifo_op_e'({wr, rd});
   endfunction

endpackage

// File: rtl/parity_checker.sv
// rtl/parity_checker.sv - combinational XOR reduction over a flit (1 = odd parity)
module parity_checker #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] data,
   output logic             err
);

   assign err = ^data;

endmodule

// File: rtl/input_fifo.sv
// rtl/input_fifo.sv - router input flit FIFO, FWFT head, optional parity check under INPUT_FIFO_PARITY_EN
module input_fifo
   import input_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int PTR_WIDTH  = FIFO_PTR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  ready_out,
   input  logic                  read_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  empty,
   output logic                  full
`ifdef INPUT_FIFO_PARITY_EN
   ,
   output logic                  parity_err
`endif
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH:0]    count_q, count_d;
   logic                  wr_accept;
   logic                  rd_accept;
   fifo_op_e              op;

   // Status decodes only look at registered count, so no valid_in/read_en path reaches them
   assign empty     = (count_q == '0);
   assign full      = (count_q == (PTR_WIDTH + 1)'(DEPTH));
   assign ready_out = !full && !rst;

   // A full FIFO refuses writes even when the head is being popped the same cycle
   assign wr_accept = valid_in && ready_out;
   assign rd_accept = read_en && !empty;

   // Head flit is shown immediately; an empty FIFO drives zero instead of stale storage
   assign data_out  = empty ? '0 : mem_q[rd_ptr_q];

   // Next-state for pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      op       = decode_op(wr_accept, rd_accept);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_accept) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case (op)
         OP_PUSH: count_d = count_q + 1'b1;
         OP_POP:  count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state register; reset discards everything by clearing pointers and count
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Flit storage is left unreset; only accepted writes touch it
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

`ifdef INPUT_FIFO_PARITY_EN
   logic wr_par_err;
   logic parity_err_d;
   logic parity_err_q;

   parity_checker #(
      .WIDTH(DATA_WIDTH)
   ) u_parity_checker (
      .data(data_in),
      .err (wr_par_err)
   );

   // Flag odd parity only for flits actually written; the flit is stored regardless
   always_comb begin
      parity_err_d = wr_accept && wr_par_err;
   end

   // One-cycle error pulse following the offending write edge
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_input_fifo.sv
// tb/tb_input_fifo.sv - table-driven bench for input_fifo
module tb_input_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [31:0] data_in;
   logic        ready_out;
   logic        read_en;
   logic [31:0] data_out;
   logic        empty;
   logic        full;
`ifdef INPUT_FIFO_PARITY_EN
   logic        parity_err;
`endif

   int n_total = 0;
   int n_pass  = 0;

   input_fifo #(
      .DATA_WIDTH(32),
      .DEPTH     (4),
      .PTR_WIDTH (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .valid_in (valid_in),
      .data_in  (data_in),
      .ready_out(ready_out),
      .read_en  (read_en),
      .data_out (data_out),
      .empty    (empty),
      .full     (full)
`ifdef INPUT_FIFO_PARITY_EN
      ,
      .parity_err(parity_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        valid;
      logic [31:0] din;
      logic        rd;
      logic        exp_ready;
      logic        exp_empty;
      logic        exp_full;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic v, input logic [31:0] d, input logic rd,
                      input logic er, input logic ee, input logic ef, input logic [31:0] ed);
      vec_t x;
      x.rst = r; x.valid = v; x.din = d; x.rd = rd;
      x.exp_ready = er; x.exp_empty = ee; x.exp_full = ef; x.exp_data = ed;
      vecs.push_back(x);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   initial begin
      rst = 1'b1; valid_in = 1'b0; data_in = '0; read_en = 1'b0;

      //   rst v  din           rd  rdy emp full data
      add(1, 0, 32'h0,        0,  0,  1,  0,  32'h0);  // reset
      add(0, 0, 32'h0,        0,  1,  1,  0,  32'h0);  // idle after reset
      add(0, 1, 32'h1,        0,  1,  0,  0,  32'h1);
      add(0, 1, 32'h2,        0,  1,  0,  0,  32'h1);
      add(0, 1, 32'h3,        0,  1,  0,  0,  32'h1);  // count 3
      add(0, 1, 32'h4,        0,  0,  0,  1,  32'h1);  // full
      add(0, 1, 32'hAA,       1,  1,  0,  0,  32'h2);  // pop only, AA dropped
      for (int k = 5; k <= 14; k++)
         add(0, 1, 32'(k),    1,  1,  0,  0,  32'(k - 2)); // streaming, pointers wrap
      add(0, 0, 32'h0,        1,  1,  0,  0,  32'd13);
      add(0, 0, 32'h0,        1,  1,  0,  0,  32'd14);
      add(0, 0, 32'h0,        1,  1,  1,  0,  32'h0);  // drained
      for (int k = 0; k < 3; k++)
         add(0, 0, 32'h0,     1,  1,  1,  0,  32'h0);  // underflow ignored
      add(0, 1, 32'h11,       1,  1,  0,  0,  32'h11); // pop ignored while empty, write lands
      add(0, 1, 32'h22,       0,  1,  0,  0,  32'h11);
      add(1, 1, 32'h33,       0,  0,  1,  0,  32'h0);  // reset discards, 33 refused
      add(0, 0, 32'h0,        0,  1,  1,  0,  32'h0);
      add(0, 1, 32'h44,       0,  1,  0,  0,  32'h44); // pointers restart cleanly
      add(0, 0, 32'h0,        1,  1,  1,  0,  32'h0);

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         rst      = vecs[i].rst;
         valid_in = vecs[i].valid;
         data_in  = vecs[i].din;
         read_en  = vecs[i].rd;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_ready", i), {31'b0, ready_out}, {31'b0, vecs[i].exp_ready});
         chk($sformatf("v%0d_empty", i), {31'b0, empty},     {31'b0, vecs[i].exp_empty});
         chk($sformatf("v%0d_full", i),  {31'b0, full},      {31'b0, vecs[i].exp_full});
         chk($sformatf("v%0d_data", i),  data_out,           vecs[i].exp_data);
      end
      rst = 1'b0; valid_in = 1'b0; read_en = 1'b0; data_in = '0;

      // ready_out drops combinationally with rst before any edge
      #1;
      rst = 1'b1;
      #1;
      chk("rst_comb_ready", {31'b0, ready_out}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("ready_after_rst", {31'b0, ready_out}, 32'd1);

      // no bypass: a write into an empty FIFO is not visible before the edge
      valid_in = 1'b1; data_in = 32'h55;
      #1;
      chk("nobypass_data", data_out, 32'h0);
      chk("nobypass_empty", {31'b0, empty}, 32'd1);
      @(posedge clk); #1;
      valid_in = 1'b0;
      chk("after_write_data", data_out, 32'h55);

`ifdef INPUT_FIFO_PARITY_EN
      chk("par_idle", {31'b0, parity_err}, 32'd0);
      valid_in = 1'b1; data_in = 32'h0000_0001;
      @(posedge clk); #1;
      valid_in = 1'b0;
      chk("par_odd", {31'b0, parity_err}, 32'd1);
      @(posedge clk); #1;
      chk("par_pulse_end", {31'b0, parity_err}, 32'd0);
      valid_in = 1'b1; data_in = 32'h8000_0001;
      @(posedge clk); #1;
      valid_in = 1'b0;
      chk("par_even", {31'b0, parity_err}, 32'd0);
      read_en = 1'b1;
      @(posedge clk); #1;
      read_en = 1'b0;
      chk("par_flit_stored", data_out, 32'h0000_0001);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
